// File: rtl/analog_ctrls.sv
`default_nettype none
// ============================================================================
//  Module      : analog_ctrls
//  Description : UART control-value receiver. Parses ASCII frames of the form
//                "MEAS:hh:hh:hh:hh:hh:hh:hh:\r\n" and updates seven control
//                registers together when the whole frame has been accepted.
//  Ports       : clk      - system clock
//                reset_n  - asynchronous active-low reset
//                CTRL_RX  - UART receive line (8N1, LSB first, idle high)
//                a8, a5, a4, blend, delay, feedbk, gain
//                         - control outputs, top BITS bits of each field
//  Revision    : 1.0 - initial release
// ============================================================================
module analog_ctrls #(
    parameter int fCLK  = 50_000_000,
    parameter int fBAUD = 9_600,
    parameter int BITS  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            CTRL_RX,
    output logic [BITS-1:0] a8,
    output logic [BITS-1:0] a5,
    output logic [BITS-1:0] a4,
    output logic [BITS-1:0] blend,
    output logic [BITS-1:0] delay,
    output logic [BITS-1:0] feedbk,
    output logic [BITS-1:0] gain
);

    localparam int c_DIV  = (fCLK + fBAUD / 2) / fBAUD;
    localparam int c_HALF = c_DIV / 2 - 1;
    localparam int c_FULL = c_DIV - 1;
    localparam int c_CW   = $clog2(c_DIV);

    // ------------------------------------------------------------------
    // Input synchronizer (resets to the idle level)
    // ------------------------------------------------------------------
    logic [1:0] r_sync;
    logic       r_rx_prev;
    logic       w_rx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], CTRL_RX};
            r_rx_prev <= r_sync[1];
        end
    end

    assign w_rx = r_sync[1];

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t         r_rx_state, w_rx_state_nx;
    logic [c_CW-1:0]   r_cnt;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_brk;        // framing error seen, waiting for line high
    logic              r_rx_valid;
    logic              r_rx_abort;
    logic [7:0]        r_rx_byte;
    logic              w_tick;
    logic              w_rx_valid;
    logic              w_rx_abort;

    // Start bit is checked at half a bit, everything else one bit apart.
    assign w_tick = (r_rx_state == RX_START) ? (r_cnt == c_CW'(c_HALF))
                                             : (r_cnt == c_CW'(c_FULL));

    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_valid    = 1'b0;
        w_rx_abort    = 1'b0;
        case (r_rx_state)
            RX_IDLE:  if (r_rx_prev && !w_rx) w_rx_state_nx = RX_START;
            RX_START: if (w_tick) w_rx_state_nx = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_tick && r_bit == 3'd7) w_rx_state_nx = RX_STOP;
            RX_STOP: begin
                if (r_brk) begin
                    if (w_rx) w_rx_state_nx = RX_IDLE;
                end else if (w_tick) begin
                    if (w_rx) begin
                        w_rx_valid    = 1'b1;
                        w_rx_state_nx = RX_IDLE;
                    end else begin
                        w_rx_abort    = 1'b1;
                    end
                end
            end
            default:  w_rx_state_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state <= RX_IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_brk      <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_abort <= 1'b0;
            r_rx_byte  <= '0;
        end else begin
            r_rx_state <= w_rx_state_nx;
            r_rx_valid <= w_rx_valid;
            r_rx_abort <= w_rx_abort;
            if (r_rx_state == RX_IDLE || w_tick)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_rx_state == RX_START)
                r_bit <= '0;
            if (r_rx_state == RX_DATA && w_tick) begin
                r_shift <= {w_rx, r_shift[7:1]};
                r_bit   <= r_bit + 1'b1;
            end
            if (w_rx_valid)
                r_rx_byte <= r_shift;
            if (w_rx_abort)
                r_brk <= 1'b1;
            else if (w_rx_state_nx == RX_IDLE)
                r_brk <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        P_HUNT, P_PREFIX, P_HI, P_LO, P_SEP, P_CR, P_LF
    } p_state_t;

    // {valid, nibble}
    function automatic logic [4:0] hex_dec(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)      hex_dec = {1'b1, 4'(c - 8'h30)};
        else if (c >= 8'h61 && c <= 8'h66) hex_dec = {1'b1, 4'(c - 8'h57)};
        else if (c >= 8'h41 && c <= 8'h46) hex_dec = {1'b1, 4'(c - 8'h37)};
        else                               hex_dec = 5'b0;
    endfunction

    function automatic logic [7:0] prefix_char(input logic [2:0] idx);
        case (idx)
            3'd1:    prefix_char = 8'h45;  // 'E'
            3'd2:    prefix_char = 8'h41;  // 'A'
            3'd3:    prefix_char = 8'h53;  // 'S'
            3'd4:    prefix_char = 8'h3A;  // ':'
            default: prefix_char = 8'h4D;  // 'M'
        endcase
    endfunction

    p_state_t    r_p_state, w_p_state_nx;
    logic [2:0]  r_idx, w_idx_nx;
    logic [2:0]  r_field;
    logic [3:0]  r_hi;
    logic [7:0]  r_asm;
    logic [7:0]  r_shadow [0:6];
    logic [BITS-1:0] r_out [0:6];
    logic [4:0]  w_hex;
    logic        w_acc;
    logic        w_ld_hi;
    logic        w_ld_lo;
    logic        w_store;
    logic        w_field_clr;
    logic        w_commit;

    assign w_hex = hex_dec(r_rx_byte);

    always_comb begin
        w_p_state_nx = r_p_state;
        w_idx_nx     = r_idx;
        w_acc        = 1'b0;
        w_ld_hi      = 1'b0;
        w_ld_lo      = 1'b0;
        w_store      = 1'b0;
        w_field_clr  = 1'b0;
        w_commit     = 1'b0;
        if (r_rx_abort) begin
            w_p_state_nx = P_HUNT;
        end else if (r_rx_valid) begin
            w_acc = 1'b1;
            case (r_p_state)
                P_HUNT:   w_acc = 1'b0;
                P_PREFIX: begin
                    if (r_rx_byte != prefix_char(r_idx)) begin
                        w_acc = 1'b0;
                    end else if (r_idx == 3'd4) begin
                        w_p_state_nx = P_HI;
                        w_field_clr  = 1'b1;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
                P_HI: begin
                    w_acc        = w_hex[4];
                    w_ld_hi      = w_hex[4];
                    w_p_state_nx = P_LO;
                end
                P_LO: begin
                    w_acc        = w_hex[4];
                    w_ld_lo      = w_hex[4];
                    w_p_state_nx = P_SEP;
                end
                P_SEP: begin
                    w_acc        = (r_rx_byte == 8'h3A);
                    w_store      = w_acc;
                    w_p_state_nx = (r_field == 3'd6) ? P_CR : P_HI;
                end
                P_CR: begin
                    w_acc        = (r_rx_byte == 8'h0D);
                    w_p_state_nx = P_LF;
                end
                P_LF: begin
                    w_acc        = (r_rx_byte == 8'h0A);
                    w_commit     = w_acc;
                    w_p_state_nx = P_HUNT;
                end
                default:  w_acc = 1'b0;
            endcase
            // Rejected byte: an 'M' restarts a frame, anything else hunts.
            if (!w_acc) begin
                w_idx_nx     = 3'd1;
                w_p_state_nx = (r_rx_byte == 8'h4D) ? P_PREFIX : P_HUNT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p_state <= P_HUNT;
            r_idx     <= '0;
            r_field   <= '0;
            r_hi      <= '0;
            r_asm     <= '0;
            for (int k = 0; k < 7; k++) begin
                r_shadow[k] <= '0;
                r_out[k]    <= '0;
            end
        end else begin
            r_p_state <= w_p_state_nx;
            r_idx     <= w_idx_nx;
            if (w_ld_hi) r_hi  <= w_hex[3:0];
            if (w_ld_lo) r_asm <= {r_hi, w_hex[3:0]};
            if (w_field_clr)
                r_field <= '0;
            else if (w_store)
                r_field <= r_field + 1'b1;
            for (int k = 0; k < 7; k++) begin
                if (w_store && r_field == 3'(k))
                    r_shadow[k] <= r_asm;
                if (w_commit)
                    r_out[k] <= r_shadow[k][7 -: BITS];
            end
        end
    end

    assign a8     = r_out[0];
    assign a5     = r_out[1];
    assign a4     = r_out[2];
    assign blend  = r_out[3];
    assign delay  = r_out[4];
    assign feedbk = r_out[5];
    assign gain   = r_out[6];

endmodule
`default_nettype wire

// File: tb/tb_analog_ctrls.sv
`default_nettype none
// ============================================================================
//  Module      : tb_analog_ctrls
//  Description : Directed self-checking bench for analog_ctrls. A reduced
//                clock/baud ratio (12 clocks per bit) keeps frames short.
//                A second instance with BITS=4 shares the receive line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_analog_ctrls;

    localparam int FCLK  = 120;
    localparam int FBAUD = 10;
    localparam int DIV   = 12;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] a8, a5, a4, blend, delay, feedbk, gain;
    logic [3:0] t_a8, t_a5, t_a4, t_blend, t_delay, t_feedbk, t_gain;

    int vectors = 0;
    int miscompares = 0;

    analog_ctrls #(.fCLK(FCLK), .fBAUD(FBAUD), .BITS(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .CTRL_RX(rx),
        .a8(a8), .a5(a5), .a4(a4), .blend(blend),
        .delay(delay), .feedbk(feedbk), .gain(gain)
    );

    analog_ctrls #(.fCLK(FCLK), .fBAUD(FBAUD), .BITS(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .CTRL_RX(rx),
        .a8(t_a8), .a5(t_a5), .a4(t_a4), .blend(t_blend),
        .delay(t_delay), .feedbk(t_feedbk), .gain(t_gain)
    );

    always #5 clk = ~clk;

    function automatic logic [55:0] outs();
        return {a8, a5, a4, blend, delay, feedbk, gain};
    endfunction

    function automatic logic [55:0] outs4();
        return {28'h0, t_a8, t_a5, t_a4, t_blend, t_delay, t_feedbk, t_gain};
    endfunction

    task automatic chk(input string tag, input logic [55:0] obs, input logic [55:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_ok;
        repeat (DIV) @(negedge clk);
        if (!stop_ok) begin
            rx = 1'b1;
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    // Sends body + CR, checks nothing moved yet, then sends LF and watches
    // for the first clock any output changes: all seven must be new there.
    task automatic send_valid(input string tag, input string body, input logic [55:0] exp);
        logic [55:0] old;
        old = outs();
        send_str(body);
        send_byte(8'h0D, 1'b1);
        chk({tag, "_pre_lf"}, outs(), old);
        fork
            send_byte(8'h0A, 1'b1);
            begin
                int n = 0;
                @(negedge clk);
                while (outs() === old && n < 12 * DIV) begin
                    @(negedge clk);
                    n++;
                end
                chk({tag, "_commit"}, outs(), exp);
            end
        join
    endtask

    initial begin
        logic [55:0] held;

        // Reset
        repeat (10) @(negedge clk);
        chk("reset", outs(), 56'h0);
        chk("reset_b4", outs4(), 56'h0);
        reset_n = 1'b1;
        repeat (5 * DIV) @(negedge clk);
        chk("idle", outs(), 56'h0);

        // First frame, also checks truncated instance
        send_valid("frame1", "MEAS:4a:36:32:45:81:d1:ea:", 56'h4a_36_32_45_81_d1_ea);
        chk("trunc4", outs4(), {28'h0, 28'h4_3_3_4_8_d_e});

        send_valid("frame2", "MEAS:6b:4c:37:35:4a:8f:d8:", 56'h6b_4c_37_35_4a_8f_d8);

        // Garbage followed immediately by a good frame
        send_str("lets test some error handling");
        chk("garbage_hold", outs(), 56'h6b_4c_37_35_4a_8f_d8);
        send_valid("frame3", "MEAS:b4:91:5f:40:2c:26:3a:", 56'hb4_91_5f_40_2c_26_3a);

        // Uppercase hex
        send_valid("frame4", "MEAS:B1:B4:8A:58:31:19:17:", 56'hb1_b4_8a_58_31_19_17);
        held = 56'hb1_b4_8a_58_31_19_17;

        // Bad hex digit
        send_str("MEAS:12:zz:34:56:78:9a:bc:");
        send_byte(8'h0D, 1'b1);
        send_byte(8'h0A, 1'b1);
        chk("badhex_hold", outs(), held);

        // Stop-bit error inside a frame
        send_str("MEAS:11:22:");
        send_byte(8'h33, 1'b0);
        send_str("3:44:55:66:77:");
        send_byte(8'h0D, 1'b1);
        send_byte(8'h0A, 1'b1);
        chk("framing_hold", outs(), held);

        // Short low glitch on an idle line
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        chk("glitch_hold", outs(), held);

        // Truncated frame interrupted by a new 'M' resynchronizes
        send_str("MEAS:1");
        send_valid("resync", "MEAS:0f:1e:2d:3c:4b:5a:69:", 56'h0f_1e_2d_3c_4b_5a_69);

        // Reset in the middle of a frame; the tail must not commit
        send_str("MEAS:11:2");
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset", outs(), 56'h0);
        chk("midreset_b4", outs4(), 56'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        send_str("2:33:44:55:66:77:");
        send_byte(8'h0D, 1'b1);
        send_byte(8'h0A, 1'b1);
        repeat (4) @(negedge clk);
        chk("partial_lost", outs(), 56'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/analog_ctrls.md
# analog_ctrls

UART-driven control-value receiver for the theremin FPGA. Receives ASCII frames at `fBAUD` on `CTRL_RX`, parses frames of the form `MEAS:hh:hh:hh:hh:hh:hh:hh:\r\n` and updates seven control registers atomically when a frame is fully valid. Malformed input is discarded and all outputs hold their previous values. The registers feed the analog/audio processing path: oscillator amplitudes, blend, delay, feedback and gain.

## Interface
- `fCLK`, default 50_000_000: system clock frequency in Hz.
- `fBAUD`, default 9_600: UART baud rate.
- `BITS`, default 8: output width, legal range 1..8. Each output is the top `BITS` bits of its received byte.

- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `CTRL_RX`  in  1  UART receive line: 8N1, LSB first, idle high, asynchronous to `clk`.
- `a8`  out  BITS  field 1.
- `a5`  out  BITS  field 2.
- `a4`  out  BITS  field 3.
- `blend`  out  BITS  field 4.
- `delay`  out  BITS  field 5.
- `feedbk`  out  BITS  field 6.
- `gain`  out  BITS  field 7.

## Operation
- **Input sync:** `CTRL_RX` passes through a 2-flop synchronizer. The synchronizer resets to 1.
- **Baud:** `DIV = round(fCLK/fBAUD)`, which is 5208 at the defaults.
- **RX FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on a falling edge.
  - START re-samples the line at `DIV/2`. If the line is high, it is a glitch: return to IDLE. If low, go to DATA.
  - DATA samples 8 bits, each `DIV` clocks apart at mid-bit, LSB first.
  - STOP samples at mid-bit.
    - Stop = 1: emit the byte with a 1-clock `rx_valid` pulse.
    - Stop = 0: framing error. No byte is emitted, a parser-abort pulse is issued, and the FSM waits for the line to return high before IDLE.
- **Parser FSM states:** HUNT, PREFIX(idx 0..4 over "MEAS:"), HI, LO, SEP, CR, LF.
  - HUNT: 'M' → PREFIX idx1. Any other byte → stay in HUNT.
  - PREFIX: an expected char advances; after ':' go to HI with field=0. On mismatch: 'M' → PREFIX idx1, otherwise → HUNT.
  - HI/LO: accept hex digits 0-9, a-f, A-F. HI stores the upper nibble, LO the lower nibble. After LO go to SEP.
  - SEP: ':' stores the byte into shadow[field] and increments field. field=7 → CR, otherwise → HI.
  - CR expects 0x0D; LF expects 0x0A.
  - On accepting LF: copy all seven shadow bytes to the outputs in the same clock, then go to HUNT.
  - Any unexpected byte in HI, LO, SEP, CR or LF: discard the frame and go to HUNT. Exception: 'M' → PREFIX idx1, so the parser resynchronizes on an immediately following frame.
  - Framing error: → HUNT.
- **Atomicity:** outputs change only on LF acceptance, and all seven change together. Shadow registers never appear on the outputs directly.
- **Truncation:** `out = shadow[7 -: BITS]`.
- **Reset mid-operation:** both FSMs return to IDLE/HUNT. Shadow registers and outputs clear to 0, and any partial frame is lost.

## Timing
- **Reset value:** all outputs are 0.
- **Byte period:** 10·DIV clocks, which is 52080 at the defaults. Back-to-back bytes are supported, with the next start edge arriving immediately after the stop bit.
- **Output latency:** outputs update 1 clock after the LF byte's stop-bit sample, roughly 9.5·DIV + 3 clocks after the LF start edge.
- **Baud tolerance:** a bit-rate error of ±2% must be tolerated.
- **Busy parser:** the parser consumes one byte per `rx_valid`. It is never busy, so no backpressure exists.

## Test plan
- **Reset:** hold `reset_n`=0 for 10 clocks → all outputs 0. Idle line after release → outputs stay 0.
- **First valid frame:** send "MEAS:4a:36:32:45:81:d1:ea:\r\n" → a8=0x4a, a5=0x36, a4=0x32, blend=0x45, delay=0x81, feedbk=0xd1, gain=0xea. All seven change in the same clock after LF.
- **Second valid frame:** send "MEAS:6b:4c:37:35:4a:8f:d8:\r\n" → outputs 0x6b, 0x4c, 0x37, 0x35, 0x4a, 0x8f, 0xd8.
- **Error handling:** send "lets test some error handling", then immediately "MEAS:b4:91:5f:40:2c:26:3a:\r\n".
  - Outputs hold 0x6b…0xd8 through the garbage.
  - After LF, outputs read 0xb4, 0x91, 0x5f, 0x40, 0x2c, 0x26, 0x3a.
- **Uppercase hex and corrupted frame:** send "MEAS:B1:B4:8A:58:31:19:17:\r\n" → outputs 0xb1, 0xb4, 0x8a, 0x58, 0x31, 0x19, 0x17. Then send "MEAS:12:zz:…\r\n" and a frame containing a stop-bit error → outputs unchanged.
- **Truncation:** with `BITS`=4, send "MEAS:4a:36:32:45:81:d1:ea:\r\n" → a8=0x4, a5=0x3, a4=0x3, blend=0x4, delay=0x8, feedbk=0xd, gain=0xe.
